keyboard_control: RTL and testbench



---
 rtl/keyboard_pkg.sv | 19 +
 rtl/keyboard_control_if.sv | 20 ++
 rtl/keyboard_control_ps2_rx.sv | 90 +++++++++
 rtl/keyboard_control.sv | 74 +++++++
 tb/tb_keyboard_control.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/keyboard_pkg.sv
// Shared constants for the PS/2 keyboard front end: arrow-key scan codes and frame size.
package keyboard_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;

    localparam int PS2_FRAME_BITS = 11;

    // A frame holds start, data, parity and stop, from bit 0 upwards.
    // It is good when start is 0, stop is 1, and data plus parity have odd parity.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[PS2_FRAME_BITS-1] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/keyboard_control_if.sv
// PS/2 pins plus the decoded arrow-key pulses. The keyboard/board side drives the
// pins, and the front end drives the pulses.
interface keyboard_control_if;
    logic ps2_clk;
    logic ps2_data;
    logic left;
    logic right;
    logic down;
    logic up;

    modport master (
        output ps2_clk, ps2_data,
        input  left, right, down, up
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output left, right, down, up
    );
endinterface

// File: rtl/keyboard_control_ps2_rx.sv
// PS/2 receiver: synchronises the raw pins, samples data on ps2_clk falling edges,
// checks each 11-bit frame, and abandons partial frames after a period of silence.
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] timer;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic          last_bit;

    // Two-flop synchronisers plus one extra stage on the clock for edge detection.
    // These reset to 1 so that an idle bus does not look like an edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall     = clk_d & ~clk_s2;
    assign last_bit = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
    // Full frame as it stands on the stop-bit edge: the stop bit is still on the data line.
    assign frame    = {dat_s2, shift};

    // Shift and bit counter. A down-counting timer is reloaded on every edge, and a
    // partial frame is dropped when the timer reaches its terminal count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt <= '0;
            shift   <= '0;
            timer   <= TW'(TIMEOUT_CYCLES - 1);
        end else if (fall) begin
            timer <= TW'(TIMEOUT_CYCLES - 1);
            shift <= {dat_s2, shift[9:1]};
            if (last_bit) bit_cnt <= '0;
            else          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt != '0) begin
            if (timer == '0) begin
                bit_cnt <= '0;
                timer   <= TW'(TIMEOUT_CYCLES - 1);
            end else begin
                timer <= timer - TW'(1);
            end
        end
    end

    // Registered byte strobe, or error strobe, one cycle after the stop-bit edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall && last_bit) begin
                rx_byte <= frame[8:1];
                if (frame_ok(frame)) rx_valid <= 1'b1;
                else                 rx_err   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/keyboard_control.sv
// Keyboard front end: receives PS/2 bytes, tracks the E0/F0 prefixes, and turns
// extended arrow-key make codes into one-cycle pulses.
module keyboard_control
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                clrn,
    keyboard_control_if.slave   kbd
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext, brk;
    logic       left_q, right_q, down_q, up_q;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (kbd.ps2_clk),
        .ps2_data (kbd.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    // Prefix tracking and pulse generation. A bad frame drops any pending prefix, and
    // any non-prefix byte ends the sequence whether or not it was an arrow key.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    if (ext && !brk) begin
                        case (rx_byte)
                            SC_LEFT:  left_q  <= 1'b1;
                            SC_RIGHT: right_q <= 1'b1;
                            SC_DOWN:  down_q  <= 1'b1;
                            SC_UP:    up_q    <= 1'b1;
                            default:  ;
                        endcase
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

    assign kbd.left  = left_q;
    assign kbd.right = right_q;
    assign kbd.down  = down_q;
    assign kbd.up    = up_q;

endmodule

// File: tb/tb_keyboard_control.sv
// Directed bench for keyboard_control: table of byte sequences with expected pulse
// counts, plus hand-written parity, timeout and mid-frame reset sequences.
module tb_keyboard_control;

    localparam int TO = 200;
    localparam int HP = 40;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   total = 0;
    int   bad = 0;

    keyboard_control_if kif();

    keyboard_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .clrn (clrn),
        .kbd  (kif.slave)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling clk edge.
    int       cnt_l = 0, cnt_r = 0, cnt_d = 0, cnt_u = 0;
    int       excl_err = 0, width_err = 0;
    logic [3:0] prev_o = '0;
    time      last_pulse_t = 0;
    time      stop_t = 0;

    always @(negedge clk) begin
        logic [3:0] o;
        o = {kif.left, kif.right, kif.down, kif.up};
        if ($countones(o) > 1) excl_err++;
        if (o != 4'b0 && o == prev_o) width_err++;
        if (o[3]) cnt_l++;
        if (o[2]) cnt_r++;
        if (o[1]) cnt_d++;
        if (o[0]) cnt_u++;
        if (o != 4'b0) last_pulse_t = $time;
        prev_o = o;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_l = 0; cnt_r = 0; cnt_d = 0; cnt_u = 0;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    // Sends the first nbits of a frame; timing is set on the falling clk edge.
    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            kif.ps2_data = f[i];
            repeat (HP) @(negedge clk);
            kif.ps2_clk = 1'b0;
            if (i == 10) stop_t = $time;
            repeat (HP) @(negedge clk);
            kif.ps2_clk = 1'b1;
        end
        @(negedge clk);
        kif.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        send_bits(mk_frame(b, flip), 11);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] counts();
        return {cnt_l[1:0], cnt_r[1:0], cnt_d[1:0], cnt_u[1:0]};
    endfunction

    typedef struct {
        logic [3:0][7:0] b;   // b[0] sent first
        int              n;
        logic [7:0]      exp; // {left,right,down,up} pulse counts, 2 bits each
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{b: {8'h00, 8'h00, 8'h6B, 8'hE0}, n: 2, exp: 8'b01_00_00_00};
        vecs[1]  = '{b: {8'h00, 8'h00, 8'h74, 8'hE0}, n: 2, exp: 8'b00_01_00_00};
        vecs[2]  = '{b: {8'h00, 8'h00, 8'h72, 8'hE0}, n: 2, exp: 8'b00_00_01_00};
        vecs[3]  = '{b: {8'h00, 8'h00, 8'h75, 8'hE0}, n: 2, exp: 8'b00_00_00_01};
        vecs[4]  = '{b: {8'h00, 8'h75, 8'hF0, 8'hE0}, n: 3, exp: 8'b00_00_00_00};
        vecs[5]  = '{b: {8'h00, 8'h00, 8'h75, 8'hE0}, n: 2, exp: 8'b00_00_00_01};
        vecs[6]  = '{b: {8'h00, 8'h00, 8'h00, 8'h75}, n: 1, exp: 8'b00_00_00_00};
        vecs[7]  = '{b: {8'h00, 8'h00, 8'h1C, 8'hE0}, n: 2, exp: 8'b00_00_00_00};
        vecs[8]  = '{b: {8'h00, 8'h00, 8'h00, 8'h6B}, n: 1, exp: 8'b00_00_00_00};
        vecs[9]  = '{b: {8'h00, 8'h6B, 8'hE0, 8'hE0}, n: 3, exp: 8'b01_00_00_00};
        vecs[10] = '{b: {8'h6B, 8'hE0, 8'h6B, 8'hE0}, n: 4, exp: 8'b10_00_00_00};

        // Reset held while ps2_clk toggles.
        kif.ps2_clk  = 1'b1;
        kif.ps2_data = 1'b1;
        clrn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(10);
            kif.ps2_clk = ~kif.ps2_clk;
            kif.ps2_data = ~kif.ps2_data;
        end
        kif.ps2_clk  = 1'b1;
        kif.ps2_data = 1'b1;
        idle(2);
        check("reset_outputs", {kif.left, kif.right, kif.down, kif.up}, 0);
        clrn = 1'b1;
        clear_counts();
        idle(100);
        check("idle_after_reset", counts(), 0);

        // Table-driven byte sequences.
        for (int v = 0; v < 11; v++) begin
            clear_counts();
            for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], 1'b0);
            idle(20);
            check($sformatf("vec%0d_pulses", v), counts(), vecs[v].exp);
            if (vecs[v].exp != 8'h00)
                check($sformatf("vec%0d_latency", v), last_pulse_t - stop_t, 40);
        end

        // Parity error drops the byte and the E0 prefix.
        clear_counts();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b1);
        idle(20);
        check("parity_bad_no_pulse", counts(), 0);
        send_byte(8'h6B, 1'b0);
        idle(20);
        check("parity_clears_ext", counts(), 0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b0);
        idle(20);
        check("parity_recover_left", counts(), 8'b01_00_00_00);

        // Partial frame abandoned by the timeout.
        clear_counts();
        send_bits(mk_frame(8'h6B, 1'b0), 5);
        idle(TO + 10);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h72, 1'b0);
        idle(20);
        check("timeout_down", counts(), 8'b00_00_01_00);
        check("timeout_latency", last_pulse_t - stop_t, 40);

        // Reset mid-frame loses the frame and the pending E0.
        clear_counts();
        send_byte(8'hE0, 1'b0);
        send_bits(mk_frame(8'h74, 1'b0), 5);
        clrn = 1'b0;
        idle(5);
        check("midreset_outputs", {kif.left, kif.right, kif.down, kif.up}, 0);
        clrn = 1'b1;
        idle(10);
        send_byte(8'h74, 1'b0);
        idle(20);
        check("midreset_no_pulse", counts(), 0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        idle(20);
        check("midreset_right", counts(), 8'b00_01_00_00);

        check("exclusive", excl_err, 0);
        check("pulse_width", width_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
